// File: rtl/flash_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : flash_scheduler                                               |
// | Purpose  : Stores the memory-game pattern (up to DEPTH steps, each a     |
// |            lamp number 0..4), appends pseudo-random steps on request and |
// |            plays the pattern on a one-hot lamp bus paced by `tick`.      |
// | Ports    : clk, resetN (async, active-low)                               |
// |            tick   - rate-divider enable, paces playback                  |
// |            clear  - synchronous pattern clear, aborts playback           |
// |            append - add one random step      start - play the pattern    |
// |            busy/done/full/length - status     led/moment - lamp outputs  |
// |            rd_addr/rd_data - combinational step read-back for checker    |
// | Options  : FLASH_SCHED_NO_REPEAT_EN - bump a step that would repeat the  |
// |            previous one to (r+1) mod 5                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module flash_scheduler #(
   parameter int DEPTH     = 32,
   parameter int ON_TICKS  = 2,
   parameter int OFF_TICKS = 1
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     tick,
   input  logic                     clear,
   input  logic                     append,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   length,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [2:0]               rd_data,
   output logic [4:0]               led,
   output logic                     moment
);

   localparam int c_aw      = $clog2(DEPTH);
   localparam int c_cnt_max = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int c_cw      = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

   localparam logic [c_aw:0]   c_len_one  = (c_aw+1)'(1);
   localparam logic [c_aw:0]   c_len_full = (c_aw+1)'(DEPTH);
   localparam logic [c_aw-1:0] c_idx_one  = c_aw'(1);
   localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
   localparam logic [c_cw-1:0] c_on_load  = c_cw'(ON_TICKS - 1);
   localparam logic [c_cw-1:0] c_off_load = c_cw'(OFF_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_ON   = 3'd2,
      S_OFF  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state;
   logic [c_aw:0]     r_length;
   logic [c_aw-1:0]   r_idx;
   logic [c_cw-1:0]   r_cnt;
   logic              r_moment;
   logic [15:0]       r_lfsr;
   logic [2:0]        r_mem [DEPTH];

   state_t            w_state_n;
   logic [c_aw:0]     w_length_n;
   logic [c_aw-1:0]   w_idx_n;
   logic [c_cw-1:0]   w_cnt_n;
   logic              w_moment_n;
   logic              w_wr_en;
   logic              w_fb;
   logic [2:0]        w_r;
   logic [2:0]        w_step;
   logic [c_aw:0]     w_len_m1;

   // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, right-shifting form.
   assign w_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   // Fold the 3-bit candidate into the lamp range 0..4.
   assign w_r      = (r_lfsr[2:0] >= 3'd5) ? (r_lfsr[2:0] - 3'd5) : r_lfsr[2:0];
   assign w_len_m1 = r_length - c_len_one;

`ifdef FLASH_SCHED_NO_REPEAT_EN
   logic [2:0] w_last;
   // Index wraps to the top word when empty; the length check masks it.
   assign w_last = r_mem[w_len_m1[c_aw-1:0]];
   assign w_step = ((r_length != '0) && (w_r == w_last))
                   ? ((w_r == 3'd4) ? 3'd0 : (w_r + 3'd1)) : w_r;
`else
   assign w_step = w_r;
`endif

   // Status and lamp outputs decode registered state only.
   assign busy    = (r_state == S_SYNC) || (r_state == S_ON) || (r_state == S_OFF);
   assign done    = (r_state == S_DONE);
   assign full    = (r_length == c_len_full);
   assign length  = r_length;
   assign moment  = r_moment;
   assign led     = (r_state == S_ON) ? (5'd1 << r_mem[r_idx]) : 5'd0;
   assign rd_data = r_mem[rd_addr];

   always_comb begin
      w_state_n  = r_state;
      w_length_n = r_length;
      w_idx_n    = r_idx;
      w_cnt_n    = r_cnt;
      w_moment_n = r_moment;
      w_wr_en    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (append && !full) begin
               w_wr_en    = 1'b1;
               w_length_n = r_length + c_len_one;
            end
            // A same-cycle append is counted before deciding if anything plays.
            if (start) begin
               w_idx_n   = '0;
               w_state_n = (w_length_n == '0) ? S_DONE : S_SYNC;
            end
         end
         S_SYNC: begin
            if (tick) begin
               w_state_n  = S_ON;
               w_cnt_n    = c_on_load;
               w_moment_n = ~r_moment;
            end
         end
         S_ON: begin
            if (tick) begin
               if (r_cnt == '0) begin
                  w_state_n = S_OFF;
                  w_cnt_n   = c_off_load;
               end else begin
                  w_cnt_n   = r_cnt - c_cnt_one;
               end
            end
         end
         S_OFF: begin
            if (tick) begin
               if (r_cnt == '0) begin
                  if ({1'b0, r_idx} == w_len_m1) begin
                     w_state_n = S_DONE;
                  end else begin
                     w_idx_n    = r_idx + c_idx_one;
                     w_state_n  = S_ON;
                     w_cnt_n    = c_on_load;
                     w_moment_n = ~r_moment;
                  end
               end else begin
                  w_cnt_n = r_cnt - c_cnt_one;
               end
            end
         end
         S_DONE: begin
            w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      // clear overrides everything; stored words are left in place.
      if (clear) begin
         w_state_n  = S_IDLE;
         w_length_n = '0;
         w_idx_n    = '0;
         w_cnt_n    = '0;
         w_wr_en    = 1'b0;
      end

      if (w_state_n == S_IDLE) begin
         w_moment_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state  <= S_IDLE;
         r_length <= '0;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_moment <= 1'b0;
         r_lfsr   <= 16'hACE1;
      end else begin
         r_state  <= w_state_n;
         r_length <= w_length_n;
         r_idx    <= w_idx_n;
         r_cnt    <= w_cnt_n;
         r_moment <= w_moment_n;
         r_lfsr   <= {w_fb, r_lfsr[15:1]};
      end
   end

   // Pattern storage is not reset; length alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_length[c_aw-1:0]] <= w_step;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flash_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_flash_scheduler                                            |
// | Purpose  : Self-checking bench for flash_scheduler. A reference model    |
// |            (queue of stored steps + LFSR sequence) predicts playback     |
// |            events into a scoreboard; a monitor compares DUT events.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_flash_scheduler;

   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int ON_T  = 2;
   localparam int OFF_T = 1;
   localparam int PER   = ON_T + OFF_T;

   logic          clk    = 1'b0;
   logic          resetN = 1'b0;
   logic          tick   = 1'b0;
   logic          clear  = 1'b0;
   logic          append = 1'b0;
   logic          start  = 1'b0;
   logic          busy, done, full, moment;
   logic [AW:0]   length;
   logic [AW-1:0] rd_addr = '0;
   logic [2:0]    rd_data;
   logic [4:0]    led;

   flash_scheduler #(.DEPTH(DEPTH), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T)) dut (
      .clk(clk), .resetN(resetN), .tick(tick), .clear(clear),
      .append(append), .start(start), .busy(busy), .done(done),
      .full(full), .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
      .led(led), .moment(moment)
   );

   always #5 clk = ~clk;

   // kind: 0 = lamp on, 1 = lamp off, 2 = done pulse. -1 fields are not checked.
   typedef struct {
      int kind;
      int val;
      int tofs;
      int cyc;
      int mom;
   } ev_t;

   ev_t         q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          tcnt   = 0;
   int          base   = 0;
   bit          in_play = 1'b0;
   bit          abort   = 1'b0;
   logic [4:0]  prev_led = '0;
   logic [15:0] m_lfsr;
   int          m_pat[$];

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // Model LFSR advances every clock from the same seed as the design.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) m_lfsr <= 16'hACE1;
      else         m_lfsr <= lfsr_next(m_lfsr);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tick) tcnt <= tcnt + 1;
   end

   always @(negedge clk) tick <= ($urandom_range(0, 2) == 0);

   function automatic int model_step();
      int r;
      r = int'(m_lfsr[2:0]);
      if (r >= 5) r = r - 5;
`ifdef FLASH_SCHED_NO_REPEAT_EN
      if (m_pat.size() > 0 && r == m_pat[$]) r = (r + 1) % 5;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic got_event(input int k, input int v);
      ev_t e;
      int  ofs;
      bit  ok;
      checks++;
      ofs = tcnt - base;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d led=%0d, required no event", k, v);
         return;
      end
      e  = q.pop_front();
      ok = (e.kind == k) && (e.val == v) &&
           (e.tofs < 0 || e.tofs == ofs) && (e.cyc < 0 || e.cyc == cyc) &&
           (e.mom < 0 || e.mom == int'(moment)) && (busy == (k != 2));
      if (!ok) begin
         errors++;
         $display("FAIL playback_event: got kind=%0d led=%0d tick_ofs=%0d cyc=%0d moment=%0d busy=%0d, required kind=%0d led=%0d tick_ofs=%0d cyc=%0d moment=%0d",
                  k, v, ofs, cyc, moment, busy, e.kind, e.val, e.tofs, e.cyc, e.mom);
      end
   endtask

   // Monitor: every lamp change or done pulse is one event.
   always @(negedge clk) begin
      if (resetN && !abort) begin
         if (led !== prev_led) begin
            if (led != 0 && !in_play) begin
               in_play = 1'b1;
               base    = tcnt;
            end
            got_event((led != 0) ? 0 : 1, int'(led));
         end
         if (done) begin
            got_event(2, 0);
            in_play = 1'b0;
         end
      end
      prev_led = led;
   end

   task automatic push_playback();
      int n;
      n = m_pat.size();
      if (n == 0) begin
         q.push_back('{kind: 2, val: 0, tofs: -1, cyc: cyc + 1, mom: -1});
      end else begin
         for (int k = 0; k < n; k++) begin
            q.push_back('{kind: 0, val: (1 << m_pat[k]), tofs: k*PER, cyc: -1, mom: (k+1) % 2});
            q.push_back('{kind: 1, val: 0, tofs: k*PER + ON_T, cyc: -1, mom: (k+1) % 2});
         end
         q.push_back('{kind: 2, val: 0, tofs: n*PER, cyc: -1, mom: -1});
      end
   endtask

   // Called at a falling edge; drives one cycle of append/start.
   task automatic issue(input bit a, input bit s);
      if (a && m_pat.size() < DEPTH) m_pat.push_back(model_step());
      if (s) push_playback();
      append = a;
      start  = s;
      @(negedge clk);
      append = 1'b0;
      start  = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_pat.delete();
      chk("length_after_clear", int'(length), 0);
   endtask

   task automatic check_mem();
      for (int i = 0; i < m_pat.size(); i++) begin
         rd_addr = i[AW-1:0];
         #1;
         chk("rd_data", int'(rd_data), m_pat[i]);
      end
      chk("length", int'(length), m_pat.size());
      chk("full", int'(full), int'(m_pat.size() == DEPTH));
      @(negedge clk);
   endtask

   // Waits for playback to drain; optionally pokes ignored append/start.
   task automatic wait_play(input int limit, input bit poke);
      int n;
      n = 0;
      while ((q.size() != 0 || busy || done) && n < limit) begin
         append = poke && busy && ($urandom_range(0, 3) == 0);
         start  = poke && busy && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n++;
      end
      append = 1'b0;
      start  = 1'b0;
      checks++;
      if (q.size() != 0 || busy) begin
         errors++;
         $display("FAIL playback_timeout: got %0d pending events busy=%0b, required 0 pending", q.size(), busy);
         q.delete();
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_full", int'(full), 0);
      chk("reset_led", int'(led), 0);
      chk("reset_moment", int'(moment), 0);
      chk("reset_length", int'(length), 0);
      resetN = 1'b1;
      @(negedge clk);

      // Three back-to-back appends, then play them.
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b0);
         chk("length_inc", int'(length), i + 1);
      end
      check_mem();
      issue(1'b0, 1'b1);
      wait_play(1000, 1'b1);
      check_mem();

      // Randomised rounds, some with start and append in the same cycle.
      for (int r = 0; r < 6; r++) begin
         do_clear();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n - 1; i++) begin
            issue(1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         if ($urandom_range(0, 1) == 0) begin
            issue(1'b1, 1'b1);
         end else begin
            issue(1'b1, 1'b0);
            issue(1'b0, 1'b1);
         end
         wait_play(2000, 1'b1);
         chk("moment_idle", int'(moment), 0);
         check_mem();
      end

      // Empty pattern: straight to done; then start+append from empty.
      do_clear();
      issue(1'b0, 1'b1);
      wait_play(20, 1'b0);
      chk("empty_led", int'(led), 0);
      issue(1'b1, 1'b1);
      wait_play(1000, 1'b0);
      check_mem();

      // Clear while a lamp is lit.
      do_clear();
      repeat (3) issue(1'b1, 1'b0);
      issue(1'b0, 1'b1);
      n = 0;
      while (led == 0 && n < 200) begin @(negedge clk); n++; end
      chk("reached_on", int'(led != 0), 1);
      abort = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_led", int'(led), 0);
      chk("clear_busy", int'(busy), 0);
      chk("clear_length", int'(length), 0);
      chk("clear_moment", int'(moment), 0);
      q.delete();
      in_play = 1'b0;
      m_pat.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("clear_no_done", int'(done), 0);
      end
      abort = 1'b0;

      // Reset asserted during a dark phase.
      repeat (3) issue(1'b1, 1'b0);
      issue(1'b0, 1'b1);
      n = 0;
      while (led == 0 && n < 200) begin @(negedge clk); n++; end
      while (!(led == 0 && busy) && n < 400) begin @(negedge clk); n++; end
      chk("reached_off", int'(led == 0 && busy), 1);
      abort  = 1'b1;
      resetN = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_led", int'(led), 0);
      chk("rst_moment", int'(moment), 0);
      chk("rst_length", int'(length), 0);
      chk("rst_full", int'(full), 0);
      @(negedge clk);
      resetN = 1'b1;
      q.delete();
      in_play = 1'b0;
      m_pat.delete();
      @(negedge clk);
      abort = 1'b0;

      // Fill to DEPTH, push two more appends that must be ignored, play all.
      for (int i = 0; i < DEPTH + 2; i++) issue(1'b1, 1'b0);
      check_mem();
`ifdef FLASH_SCHED_NO_REPEAT_EN
      for (int i = 1; i < DEPTH; i++) begin
         logic [2:0] prev;
         rd_addr = (i - 1);
         #1 prev = rd_data;
         rd_addr = i[AW-1:0];
         #1 chk("no_repeat", int'(rd_data != prev), 1);
      end
      @(negedge clk);
`endif
      issue(1'b0, 1'b1);
      wait_play(3000, 1'b1);
      check_mem();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
